// File: rtl/acq_trigger_ctrl_if.sv
// -----------------------------------------------------------------------------
// acq_trigger_ctrl_if
//
// Purpose: groups the sample stream coming from the LVDS deserialiser and the
// write port of the downstream sample FIFO into one bundle, so the
// acquisition controller has a single bus port.
//
// Signals:
//   samples      NCH*SW  parallel sample word, lane k at [k*SW +: SW]
//   sample_valid 1       samples carry a new word this cycle
//   fifo_used    FIFO_AW downstream FIFO fill level
//   fifo_wr      1       FIFO write strobe
//   fifo_data    NCH*SW  FIFO write data
//
// Handshake: there is no ready signal on either side. sample_valid qualifies
// samples on the cycle it is high; the producer never stalls. fifo_wr
// qualifies fifo_data on the cycle it is high, and the FIFO accepts every
// strobe. Back-pressure is by level only: the controller watches fifo_used and
// stops writing before the FIFO can overflow.
//
// Modports:
//   master  the acquisition controller (consumes samples, writes the FIFO)
//   slave   the environment (deserialiser + FIFO)
// -----------------------------------------------------------------------------
interface acq_trigger_ctrl_if #(
    parameter int NCH     = 14,
    parameter int SW      = 12,
    parameter int FIFO_AW = 11
) ();
    logic [NCH*SW-1:0]  samples;
    logic               sample_valid;
    logic [FIFO_AW-1:0] fifo_used;
    logic               fifo_wr;
    logic [NCH*SW-1:0]  fifo_data;

    modport master (
        input  samples,
        input  sample_valid,
        input  fifo_used,
        output fifo_wr,
        output fifo_data
    );

    modport slave (
        output samples,
        output sample_valid,
        output fifo_used,
        input  fifo_wr,
        input  fifo_data
    );
endinterface

// File: rtl/acq_trigger_ctrl.sv
// -----------------------------------------------------------------------------
// acq_trigger_ctrl
//
// Purpose: acquisition/trigger controller for the ADC board. Takes NCH
// parallel ADC samples per clock, waits for a programmable trigger (immediate,
// rising/falling threshold crossing on one lane, or an external level
// sequence), then streams up to capture_len sample words into the downstream
// FIFO. Supports holdoff after arm, auto-trigger timeout, FIFO back-off with a
// truncation flag and abort. Runs entirely in the sample clock domain.
//
// Ports:
//   clk, rstn        sample clock, asynchronous active-low reset
//   arm              pulse: start an acquisition (only honoured in IDLE)
//   abort            pulse: return to IDLE from any state (beats arm)
//   trig_mode        0 immediate, 1 rising, 2 falling, 3 external
//   trig_chan        lane used for the threshold comparison
//   lower_thresh     signed lower threshold
//   upper_thresh     signed upper threshold
//   ext_trig         external trigger level (mode 3)
//   capture_len      number of words to write
//   holdoff          valid samples ignored after arm
//   timeout          auto-trigger after this many waiting samples (0 = off)
//   bus              sample stream in / FIFO write port out (master side)
//   busy             high whenever the FSM is not in IDLE
//   status           {state[2:0], triggered, auto_trig, truncated, 2'b00}
//   words_written    words written in the current or last capture
//
// Configuration inputs are captured on arm and the captured copy is used for
// the whole acquisition, so software may reprogram them while busy.
// -----------------------------------------------------------------------------
module acq_trigger_ctrl #(
    parameter int NCH         = 14,
    parameter int SW          = 12,
    parameter int LW          = 16,
    parameter int FIFO_AW     = 11,
    parameter int FIFO_MARGIN = 4,
    localparam int CW         = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 arm,
    input  logic                 abort,
    input  logic [1:0]           trig_mode,
    input  logic [CW-1:0]        trig_chan,
    input  logic signed [SW-1:0] lower_thresh,
    input  logic signed [SW-1:0] upper_thresh,
    input  logic                 ext_trig,
    input  logic [LW-1:0]        capture_len,
    input  logic [LW-1:0]        holdoff,
    input  logic [LW-1:0]        timeout,
    acq_trigger_ctrl_if.master   bus,
    output logic                 busy,
    output logic [7:0]           status,
    output logic [LW-1:0]        words_written
);

    localparam int DW = NCH * SW;

    // Capture stops once the FIFO holds this many words or more.
    localparam int              FIFO_LIMIT_I = (1 << FIFO_AW) - FIFO_MARGIN;
    localparam logic [FIFO_AW:0] FIFO_LIMIT  = FIFO_LIMIT_I[FIFO_AW:0];

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_HOLDOFF = 3'd1,
        S_WAIT_A  = 3'd2,
        S_WAIT_B  = 3'd3,
        S_CAPTURE = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t               state_q;

    // Configuration captured on arm.
    logic [1:0]           mode_q;
    logic [CW-1:0]        chan_q;
    logic signed [SW-1:0] lo_q;
    logic signed [SW-1:0] hi_q;
    logic [LW-1:0]        len_q;
    logic [LW-1:0]        hold_q;
    logic [LW-1:0]        tmo_q;

    // Shared sample counter: counts holdoff samples in HOLDOFF, then is
    // cleared and counts waiting samples for the timeout in WAIT_A/WAIT_B.
    logic [LW-1:0]        cnt_q;
    logic [LW-1:0]        ww_q;
    logic                 trig_q;
    logic                 auto_q;
    logic                 trunc_q;
    logic                 wr_q;
    logic [DW-1:0]        data_q;

    // ---------------------------------------------------------------
    // Combinational helpers
    // ---------------------------------------------------------------
    logic signed [SW-1:0] lane;
    logic                 cond_a;
    logic                 cond_b;
    logic [LW-1:0]        cnt_inc;
    logic [LW-1:0]        ww_inc;
    logic                 hold_done;
    logic                 tmo_hit;
    logic                 fifo_full;

    // Lane mux; an out-of-range channel compares against zero.
    always_comb begin
        lane = '0;
        for (int k = 0; k < NCH; k++) begin
            if (chan_q == CW'(k)) begin
                lane = bus.samples[k*SW +: SW];
            end
        end
    end

    // cond_a arms the edge detector, cond_b completes it.
    always_comb begin
        cond_a = 1'b0;
        cond_b = 1'b0;
        case (mode_q)
            2'd1: begin
                cond_a = (lane < lo_q);
                cond_b = (lane > hi_q);
            end
            2'd2: begin
                cond_a = (lane > hi_q);
                cond_b = (lane < lo_q);
            end
            2'd3: begin
                cond_a = !ext_trig;
                cond_b = ext_trig;
            end
            default: begin
                cond_a = 1'b0;
                cond_b = 1'b0;
            end
        endcase
    end

    // Counters saturate instead of wrapping.
    assign cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + LW'(1);
    assign ww_inc    = (ww_q == '1) ? ww_q : ww_q + LW'(1);
    assign hold_done = (cnt_inc >= hold_q);
    assign tmo_hit   = (tmo_q != '0) && (cnt_inc == tmo_q);
    assign fifo_full = ({1'b0, bus.fifo_used} >= FIFO_LIMIT);

    // ---------------------------------------------------------------
    // FSM with registered outputs
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            mode_q  <= 2'd0;
            chan_q  <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            len_q   <= '0;
            hold_q  <= '0;
            tmo_q   <= '0;
            cnt_q   <= '0;
            ww_q    <= '0;
            trig_q  <= 1'b0;
            auto_q  <= 1'b0;
            trunc_q <= 1'b0;
            wr_q    <= 1'b0;
            data_q  <= '0;
        end else begin
            // The write strobe is a single-cycle pulse per accepted sample.
            wr_q <= 1'b0;

            if (abort) begin
                // Flags and word count stay visible for software after abort.
                state_q <= S_IDLE;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (arm) begin
                            mode_q  <= trig_mode;
                            chan_q  <= trig_chan;
                            lo_q    <= lower_thresh;
                            hi_q    <= upper_thresh;
                            len_q   <= capture_len;
                            hold_q  <= holdoff;
                            tmo_q   <= timeout;
                            cnt_q   <= '0;
                            ww_q    <= '0;
                            trig_q  <= 1'b0;
                            auto_q  <= 1'b0;
                            trunc_q <= 1'b0;
                            if (trig_mode == 2'd0) begin
                                state_q <= S_CAPTURE;
                            end else if (holdoff == '0) begin
                                state_q <= S_WAIT_A;
                            end else begin
                                state_q <= S_HOLDOFF;
                            end
                        end
                    end

                    S_HOLDOFF: begin
                        if (bus.sample_valid) begin
                            if (hold_done) begin
                                cnt_q   <= '0;
                                state_q <= S_WAIT_A;
                            end else begin
                                cnt_q <= cnt_inc;
                            end
                        end
                    end

                    S_WAIT_A, S_WAIT_B: begin
                        if (bus.sample_valid) begin
                            cnt_q <= cnt_inc;
                            // A real trigger beats a simultaneous timeout.
                            if ((state_q == S_WAIT_B) && cond_b) begin
                                trig_q  <= 1'b1;
                                state_q <= S_CAPTURE;
                            end else if (tmo_hit) begin
                                auto_q  <= 1'b1;
                                state_q <= S_CAPTURE;
                            end else if ((state_q == S_WAIT_A) && cond_a) begin
                                state_q <= S_WAIT_B;
                            end
                        end
                    end

                    S_CAPTURE: begin
                        if (ww_q >= len_q) begin
                            // Covers capture_len == 0.
                            state_q <= S_DONE;
                        end else if (bus.sample_valid) begin
                            if (fifo_full) begin
                                // Drop this word and end the capture for good.
                                trunc_q <= 1'b1;
                                state_q <= S_DONE;
                            end else begin
                                wr_q   <= 1'b1;
                                data_q <= bus.samples;
                                ww_q   <= ww_inc;
                                if (ww_inc == len_q) begin
                                    state_q <= S_DONE;
                                end
                            end
                        end
                    end

                    S_DONE: begin
                        state_q <= S_IDLE;
                    end

                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    // ---------------------------------------------------------------
    // Outputs (all driven straight from registers)
    // ---------------------------------------------------------------
    assign bus.fifo_wr   = wr_q;
    assign bus.fifo_data = data_q;
    assign busy          = (state_q != S_IDLE);
    assign status        = {state_q, trig_q, auto_q, trunc_q, 2'b00};
    assign words_written = ww_q;

endmodule

// File: tb/tb_acq_trigger_ctrl.sv
// -----------------------------------------------------------------------------
// tb_acq_trigger_ctrl
//
// Each scenario is a table of per-cycle inputs (samples, valid, ext_trig,
// fifo_used, extra arm pulses, abort cycle). Cycle 0 carries the arm pulse and
// the configuration; later cycles drive random configuration values, which the
// DUT must ignore. A reference model scans the same table using the trigger
// rules directly and produces the expected write words, the cycle each write
// appears, the final flags and the word count.
// -----------------------------------------------------------------------------
module tb_acq_trigger_ctrl;

  localparam int NCH         = 14;
  localparam int SW          = 12;
  localparam int LW          = 16;
  localparam int FIFO_AW     = 11;
  localparam int FIFO_MARGIN = 4;
  localparam int CW          = $clog2(NCH);
  localparam int DW          = NCH * SW;
  localparam int MAXC        = 160;
  localparam int FIFO_LIMIT  = (1 << FIFO_AW) - FIFO_MARGIN;

  // ---------------- clock / reset / DUT ----------------
  logic                 clk = 1'b0;
  logic                 rstn;
  logic                 arm;
  logic                 abort;
  logic [1:0]           trig_mode;
  logic [CW-1:0]        trig_chan;
  logic signed [SW-1:0] lower_thresh;
  logic signed [SW-1:0] upper_thresh;
  logic                 ext_trig;
  logic [LW-1:0]        capture_len;
  logic [LW-1:0]        holdoff;
  logic [LW-1:0]        timeout;
  logic                 busy;
  logic [7:0]           status;
  logic [LW-1:0]        words_written;

  always #5 clk = ~clk;

  acq_trigger_ctrl_if #(.NCH(NCH), .SW(SW), .FIFO_AW(FIFO_AW)) bus_if ();

  acq_trigger_ctrl #(
    .NCH(NCH), .SW(SW), .LW(LW), .FIFO_AW(FIFO_AW), .FIFO_MARGIN(FIFO_MARGIN)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .arm          (arm),
    .abort        (abort),
    .trig_mode    (trig_mode),
    .trig_chan    (trig_chan),
    .lower_thresh (lower_thresh),
    .upper_thresh (upper_thresh),
    .ext_trig     (ext_trig),
    .capture_len  (capture_len),
    .holdoff      (holdoff),
    .timeout      (timeout),
    .bus          (bus_if),
    .busy         (busy),
    .status       (status),
    .words_written(words_written)
  );

  // ---------------- scenario tables ----------------
  logic [DW-1:0]      smp_a  [MAXC];
  logic               vld_a  [MAXC];
  logic               ext_a  [MAXC];
  logic [FIFO_AW-1:0] used_a [MAXC];
  logic               arm_x  [MAXC];
  int n_cyc;
  int abort_at;
  int c_mode, c_chan, c_lo, c_hi, c_len, c_hold, c_tmo;

  // ---------------- scoreboard ----------------
  logic [DW-1:0] exp_q[$];
  int            exp_cyc_q[$];
  logic [DW-1:0] got_q[$];
  int            got_cyc_q[$];
  bit e_trig, e_auto, e_trunc;
  int e_ww;
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic int lane_of_word(input logic [DW-1:0] w, input int k);
    logic signed [SW-1:0] t;
    t = w[k*SW +: SW];
    return int'(t);
  endfunction

  function automatic int lane_of(input int c, input int k);
    return lane_of_word(smp_a[c], k);
  endfunction

  task automatic set_lane(input int c, input int k, input int val);
    smp_a[c][k*SW +: SW] = SW'(val);
  endtask

  function automatic int first_cyc();
    return (got_cyc_q.size() > 0) ? got_cyc_q[0] : -1;
  endfunction

  task automatic fill_default();
    n_cyc = 60; abort_at = n_cyc - 1;
    c_mode = 0; c_chan = 0; c_lo = -10; c_hi = 10;
    c_hold = 0; c_tmo = 0; c_len = 5;
    for (int c = 0; c < MAXC; c++) begin
      for (int k = 0; k < NCH; k++) smp_a[c][k*SW +: SW] = SW'($urandom);
      vld_a[c]  = 1'b1;
      ext_a[c]  = 1'($urandom_range(0, 1));
      used_a[c] = FIFO_AW'($urandom_range(0, 100));
      arm_x[c]  = 1'b0;
    end
  endtask

  // ---------------- reference model ----------------
  // Walks the cycle table: holdoff discards the first c_hold valid samples,
  // then the trigger waits for the arming condition followed by the firing
  // condition (or the timeout), then up to c_len valid words are written,
  // each in the cycle its sample arrives, until the FIFO gets too full.
  task automatic run_model();
    int c, hv, cnt, dec, wr, v;
    bit stage_b, a_ok, f_ok;
    exp_q.delete(); exp_cyc_q.delete();
    e_trig = 0; e_auto = 0; e_trunc = 0; dec = -1;
    if (c_mode == 0) dec = 0;
    else begin
      c = 1; hv = 0;
      while (hv < c_hold && c < abort_at) begin
        if (vld_a[c]) hv++;
        c++;
      end
      cnt = 0; stage_b = 0;
      while (dec < 0 && c < abort_at) begin
        if (vld_a[c]) begin
          cnt++;
          v = lane_of(c, c_chan);
          case (c_mode)
            1:       begin a_ok = (v < c_lo); f_ok = (v > c_hi); end
            2:       begin a_ok = (v > c_hi); f_ok = (v < c_lo); end
            default: begin a_ok = !ext_a[c]; f_ok = ext_a[c]; end
          endcase
          if (stage_b && f_ok) begin e_trig = 1; dec = c; end
          else if (c_tmo != 0 && cnt == c_tmo) begin e_auto = 1; dec = c; end
          else if (a_ok) stage_b = 1;
        end
        c++;
      end
    end
    if (dec >= 0) begin
      wr = 0;
      for (int k = dec + 1; k < abort_at; k++) begin
        if (wr >= c_len) break;
        if (vld_a[k]) begin
          if (int'(used_a[k]) >= FIFO_LIMIT) begin e_trunc = 1; break; end
          exp_q.push_back(smp_a[k]);
          exp_cyc_q.push_back(k);
          wr++;
        end
      end
    end
    e_ww = exp_q.size();
  endtask

  // ---------------- driver ----------------
  task automatic step(input int c);
    arm   = (c == 0) || arm_x[c];
    abort = (c == abort_at);
    if (c == 0) begin
      trig_mode    = 2'(c_mode);
      trig_chan    = CW'(c_chan);
      lower_thresh = SW'(c_lo);
      upper_thresh = SW'(c_hi);
      capture_len  = LW'(c_len);
      holdoff      = LW'(c_hold);
      timeout      = LW'(c_tmo);
    end else begin
      trig_mode    = 2'($urandom);
      trig_chan    = CW'($urandom);
      lower_thresh = SW'($urandom);
      upper_thresh = SW'($urandom);
      capture_len  = LW'($urandom);
      holdoff      = LW'($urandom);
      timeout      = LW'($urandom);
    end
    bus_if.samples      = smp_a[c];
    bus_if.sample_valid = vld_a[c];
    bus_if.fifo_used    = used_a[c];
    ext_trig            = ext_a[c];
    @(posedge clk); #1;
    if (bus_if.fifo_wr === 1'b1) begin
      got_q.push_back(bus_if.fifo_data);
      got_cyc_q.push_back(c);
    end
  endtask

  task automatic go_idle();
    arm = 1'b0; abort = 1'b0; bus_if.sample_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic run_scen(input string name);
    int n;
    run_model();
    got_q.delete(); got_cyc_q.delete();
    for (int c = 0; c < n_cyc; c++) step(c);
    go_idle();
    check({name, " nwr"}, DW'(got_q.size()), DW'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s data%0d", name, i), got_q[i], exp_q[i]);
      check($sformatf("%s cyc%0d", name, i), DW'(got_cyc_q[i]), DW'(exp_cyc_q[i]));
    end
    check({name, " ww"}, DW'(words_written), DW'(e_ww));
    check({name, " status"}, DW'(status), DW'({3'd0, e_trig, e_auto, e_trunc, 2'b00}));
    check({name, " busy"}, DW'(busy), DW'(0));
  endtask

  // Reset asserted mid-cycle while waiting (WAIT_B) or while capturing.
  task automatic reset_mid(input bit in_capture);
    string tag;
    tag = in_capture ? "rst_cap" : "rst_waitb";
    fill_default();
    abort_at = MAXC - 1;
    c_len = 50;
    if (in_capture) c_mode = 0;
    else begin
      c_mode = 1;
      for (int c = 1; c < MAXC; c++) set_lane(c, 0, 0);
      set_lane(1, 0, -20);
    end
    got_q.delete(); got_cyc_q.delete();
    for (int c = 0; c < 5; c++) step(c);
    if (in_capture) check({tag, " pre_wr"}, DW'(bus_if.fifo_wr), DW'(1));
    else check({tag, " pre_state"}, DW'(status[7:5]), DW'(3));
    #2 rstn = 1'b0;
    #1;
    check({tag, " wr"}, DW'(bus_if.fifo_wr), DW'(0));
    check({tag, " data"}, bus_if.fifo_data, DW'(0));
    check({tag, " busy"}, DW'(busy), DW'(0));
    check({tag, " status"}, DW'(status), DW'(0));
    check({tag, " ww"}, DW'(words_written), DW'(0));
    arm = 1'b0;
    @(negedge clk) rstn = 1'b1;
    @(posedge clk); #1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rstn = 1'b0; arm = 1'b0; abort = 1'b0;
    trig_mode = '0; trig_chan = '0; lower_thresh = '0; upper_thresh = '0;
    ext_trig = 1'b0; capture_len = '0; holdoff = '0; timeout = '0;
    bus_if.samples = '0; bus_if.sample_valid = 1'b0; bus_if.fifo_used = '0;
    repeat (3) @(posedge clk);
    @(negedge clk) rstn = 1'b1;
    @(posedge clk); #1;
    check("reset wr", DW'(bus_if.fifo_wr), DW'(0));
    check("reset data", bus_if.fifo_data, DW'(0));
    check("reset busy", DW'(busy), DW'(0));
    check("reset status", DW'(status), DW'(0));
    check("reset ww", DW'(words_written), DW'(0));

    // Immediate trigger, 5 words, first write two cycles after arm.
    fill_default(); c_mode = 0; c_len = 5;
    run_scen("s1_imm");
    check("s1 nwr5", DW'(got_q.size()), DW'(5));
    check("s1 first_cyc", DW'(first_cyc()), DW'(1));
    check("s1 ww5", DW'(words_written), DW'(5));
    check("s1 flags", DW'(status[4:2]), DW'(0));

    // Rising edge on lane 3: 0,-20,0,20,5 -> capture starts with the 5.
    fill_default(); c_mode = 1; c_chan = 3; c_len = 4;
    set_lane(1, 3, 0); set_lane(2, 3, -20); set_lane(3, 3, 0);
    set_lane(4, 3, 20); set_lane(5, 3, 5);
    run_scen("s2_rise");
    check("s2 first_cyc", DW'(first_cyc()), DW'(5));
    check("s2 first_lane3", DW'(got_q.size() > 0 ? lane_of_word(got_q[0], 3) : -1), DW'(5));
    check("s2 triggered", DW'(status[4]), DW'(1));

    // Falling edge with holdoff 4: the edge in samples 1-2 is ignored,
    // the edge formed by samples 7 and 9 triggers.
    fill_default(); c_mode = 2; c_chan = 0; c_hold = 4;
    set_lane(1, 0, 20);  set_lane(2, 0, -20); set_lane(3, 0, 0);
    set_lane(4, 0, 20);  set_lane(5, 0, -20); set_lane(6, 0, 0);
    set_lane(7, 0, 20);  set_lane(8, 0, 0);   set_lane(9, 0, -20);
    run_scen("s3_hold");
    check("s3 first_cyc", DW'(first_cyc()), DW'(10));
    check("s3 triggered", DW'(status[4]), DW'(1));

    // Auto trigger after 8 quiet samples.
    fill_default(); c_mode = 1; c_tmo = 8;
    for (int c = 1; c < MAXC; c++) set_lane(c, 0, 0);
    run_scen("s4_auto");
    check("s4 first_cyc", DW'(first_cyc()), DW'(9));
    check("s4 auto", DW'(status[3]), DW'(1));
    check("s4 trig", DW'(status[4]), DW'(0));

    // FIFO back-off after 30 words.
    fill_default(); c_mode = 0; c_len = 100;
    for (int c = 31; c < MAXC; c++) used_a[c] = FIFO_AW'(2044);
    run_scen("s5_full");
    check("s5 ww30", DW'(words_written), DW'(30));
    check("s5 trunc", DW'(status[2]), DW'(1));

    // Abort after word 7, with arm pulses while busy.
    fill_default(); c_mode = 0; c_len = 50; abort_at = 8;
    arm_x[3] = 1'b1; arm_x[5] = 1'b1;
    run_scen("s6_abort");
    check("s6 ww7", DW'(words_written), DW'(7));
    check("s6 trunc", DW'(status[2]), DW'(0));

    // Randomized scenarios.
    for (int t = 0; t < 40; t++) begin
      fill_default();
      n_cyc  = 120;
      c_mode = $urandom_range(0, 3);
      c_chan = $urandom_range(0, NCH - 1);
      c_lo   = $urandom_range(0, 30); c_lo = -c_lo;
      c_hi   = $urandom_range(0, 30);
      c_hold = $urandom_range(0, 6);
      c_tmo  = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 25);
      c_len  = $urandom_range(0, 20);
      abort_at = ($urandom_range(0, 2) == 0) ? $urandom_range(1, n_cyc - 1) : n_cyc - 1;
      for (int c = 0; c < n_cyc; c++) begin
        int v;
        v = $urandom_range(0, 100);
        set_lane(c, c_chan, v - 50);
        vld_a[c] = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 39) == 0) used_a[c] = FIFO_AW'($urandom_range(FIFO_LIMIT - 2, (1 << FIFO_AW) - 1));
      end
      run_scen($sformatf("rnd%0d", t));
    end

    reset_mid(1'b0);
    reset_mid(1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/acq_trigger_ctrl.md
Name: acq_trigger_ctrl

Overview:
Parametrised acquisition/trigger controller for the ADC board. It takes NCH parallel ADC samples per clock, waits for a programmable trigger, then streams LENGTH sample words into a downstream FIFO. It generalises the fixed 14-lane, 12-bit threshold acquisition loop with selectable trigger channel, edge polarity, external trigger, holdoff, auto-trigger timeout, FIFO back-off and status reporting. It sits between the LVDS deserialiser and the sample FIFO that the command processor reads; it runs entirely in the sample clock domain.

Parameters:
NCH, 14, number of sample lanes per clock word
SW, 12, bits per sample (two's complement)
LW, 16, width of length, holdoff and timeout counters
FIFO_AW, 11, FIFO used-count width
FIFO_MARGIN, 4, words kept free in the FIFO; capture stops when used >= 2^FIFO_AW - FIFO_MARGIN

Ports:
clk  in  1  sample clock
rstn  in  1  asynchronous active-low reset
arm  in  1  one-cycle pulse; starts an acquisition when idle
abort  in  1  one-cycle pulse; returns to IDLE from any state
trig_mode  in  2  0 immediate, 1 rising, 2 falling, 3 external
trig_chan  in  clog2(NCH)  lane used for threshold comparison
lower_thresh  in  SW  signed lower threshold
upper_thresh  in  SW  signed upper threshold
ext_trig  in  1  external trigger level (mode 3)
capture_len  in  LW  number of sample words to write
holdoff  in  LW  samples ignored after arm before the trigger is qualified
timeout  in  LW  auto-trigger after this many qualified samples; 0 disables it
samples  in  NCH*SW  lane k occupies bits [k*SW +: SW]
sample_valid  in  1  samples valid this cycle
fifo_used  in  FIFO_AW  downstream FIFO fill level
fifo_wr  out  1  FIFO write strobe (registered)
fifo_data  out  NCH*SW  FIFO write data (registered)
busy  out  1  high in any state except IDLE
status  out  8  {state[2:0], triggered, auto_trig, truncated, 2'b00}
words_written  out  LW  words written in the current or last capture

Behaviour:
- Reset: the FSM goes to IDLE. fifo_wr=0, fifo_data=0, words_written=0, and the triggered, auto_trig and truncated flags all clear.
- Configuration inputs are latched on arm and held until the FSM returns to IDLE. Changes made while busy have no effect.
- States and encodings: IDLE=0, HOLDOFF=1, WAIT_A=2, WAIT_B=3, CAPTURE=4, DONE=5.
- IDLE: on arm, clear the flags and words_written, then go to HOLDOFF. If the latched holdoff is 0, go directly to WAIT_A. Mode 0 always goes directly to CAPTURE.
- HOLDOFF: count sample_valid cycles. After holdoff of them, go to WAIT_A.
- Trigger sample: the selected lane is samples[trig_chan*SW +: SW], compared signed against the thresholds.
- WAIT_A:
  - Mode 1 needs the sample < lower_thresh.
  - Mode 2 needs the sample > upper_thresh.
  - Mode 3 needs ext_trig == 0 (arming on a low level).
  - When met, go to WAIT_B.
- WAIT_B:
  - Mode 1 needs the sample > upper_thresh.
  - Mode 2 needs the sample < lower_thresh.
  - Mode 3 needs ext_trig == 1.
  - When met, set triggered and go to CAPTURE.
- Conditions are only evaluated on cycles with sample_valid.
- Timeout:
  - In WAIT_A/WAIT_B, a counter increments on each valid sample.
  - When the counter reaches timeout (timeout != 0), set auto_trig and go to CAPTURE. triggered stays 0.
  - If the auto and the real trigger conditions hold in the same cycle, the real trigger wins: triggered=1, auto_trig=0.
- CAPTURE:
  - The first word captured is the sample arriving in the cycle after the trigger decision, so arm-to-first-write latency is ≥ 2 cycles in mode 0.
  - On each sample_valid cycle: fifo_data<=samples, fifo_wr<=1, words_written++.
  - fifo_wr=0 on cycles without sample_valid.
  - When words_written reaches capture_len, go to DONE. No further writes occur.
  - capture_len=0: go to DONE with zero writes.
- FIFO back-off:
  - If fifo_used >= 2^FIFO_AW - FIFO_MARGIN in CAPTURE, suppress the write that cycle.
  - Set truncated and go to DONE; the capture is not resumed.
- DONE: one cycle; fifo_wr=0, then go to IDLE. Flags and words_written hold until the next arm.
- abort: takes priority over everything. Next state is IDLE, and fifo_wr=0 on the following cycle. Flags are retained; abort does not set truncated.
- arm while busy is ignored. arm and abort in the same cycle: abort wins.
- Counters saturate and never wrap: words_written ≤ capture_len ≤ 2^LW-1.
- Reset asserted mid-capture: fifo_wr drops asynchronously, and the partial capture is not reported.

Test Plan:
- Mode 0, capture_len=5, sample_valid constant → exactly 5 fifo_wr pulses, words_written=5, then busy drops; status triggered=0, auto=0, truncated=0.
- Mode 1, trig_chan=3, lower=-10, upper=10; lane 3 sequence 0,-20,0,20,5 → capture starts with the word after the 20 sample, triggered=1.
- Mode 2, holdoff=4, timeout=0; qualifying falling edge within the first 4 samples → ignored; a later edge triggers capture.
- Mode 1, timeout=8, lane stays at 0 → after 8 valid samples capture starts with auto_trig=1, triggered=0.
- capture_len=100, fifo_used forced to 2044 (FIFO_AW=11, margin 4) after 30 writes → writes stop, words_written=30, truncated=1.
- abort mid-capture at word 7 → fifo_wr low the next cycle, FSM in IDLE, words_written=7; arm pulses while busy are ignored; async reset mid-WAIT_B → all outputs 0.
